// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-master round-robin arbiter for the Avalon-MM SDRAM controller slave port
//
// Master 0 (vector load/store) and master 1 (buffer/DMA) share one slave.
// The grant is held for up to BURST_MAX accepted transfers. Reads are
// tagged with the issuing master in a small ID FIFO so each readdatavalid
// is routed back to its owner.
//
// Build option: define SDR_ARB_FIXED_PRIO_EN to make master 0 always win
// arbitration in IDLE instead of alternating with master 1.
module sdram_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 16,
  parameter int RD_DEPTH  = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // master 0
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_n_i,
  input  logic                m0_chipselect_i,
  input  logic                m0_read_n_i,
  input  logic                m0_write_n_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdatavalid_o,
  output logic                m0_waitrequest_o,
  // master 1
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_n_i,
  input  logic                m1_chipselect_i,
  input  logic                m1_read_n_i,
  input  logic                m1_write_n_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdatavalid_o,
  output logic                m1_waitrequest_o,
  // SDRAM controller slave port
  output logic [ADDR_W-1:0]   sdr_slave_address_o,
  output logic [DATA_W/8-1:0] sdr_slave_byteenable_n_o,
  output logic                sdr_slave_chipselect_o,
  output logic [DATA_W-1:0]   sdr_slave_writedata_o,
  output logic                sdr_slave_read_n_o,
  output logic                sdr_slave_write_n_o,
  input  logic [DATA_W-1:0]   sdr_slave_readdata_i,
  input  logic                sdr_slave_readdatavalid_i,
  input  logic                sdr_slave_waitrequest_i,
  // sticky: a read return arrived with no outstanding read recorded
  output logic                err_orphan_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam int PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(RD_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             gnt_last_q, gnt_last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_orphan_q, err_orphan_d;
  logic             id_mem_q [RD_DEPTH];

  logic req0, req1, rd0, rd1;
  logic win;
  logic gnt, sel;
  logic s_req, s_rd;
  logic fifo_full, fifo_empty;
  logic block, accept, push, pop, head;

  assign req0 = m0_chipselect_i & (~m0_read_n_i | ~m0_write_n_i);
  assign req1 = m1_chipselect_i & (~m1_read_n_i | ~m1_write_n_i);
  assign rd0  = req0 & ~m0_read_n_i;
  assign rd1  = req1 & ~m1_read_n_i;

`ifdef SDR_ARB_FIXED_PRIO_EN
  // Master 0 wins whenever it asks; gnt_last is kept but not consulted.
  assign win = req0 ? 1'b0 : 1'b1;
`else
  // On a tie the master that did not hold the last grant wins.
  assign win = (req0 & req1) ? ~gnt_last_q : req1;
`endif

  assign gnt   = (state_q == GNT0) || (state_q == GNT1);
  assign sel   = (state_q == GNT1);
  assign s_req = sel ? req1 : req0;
  assign s_rd  = sel ? rd1 : rd0;

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);

  // A granted read is held off while no ID slot is free (pre-pop count).
  assign block  = gnt & s_rd & fifo_full;
  assign accept = gnt & s_req & ~block & ~sdr_slave_waitrequest_i;
  assign push   = accept & s_rd;
  assign pop    = sdr_slave_readdatavalid_i & ~fifo_empty;
  assign head   = id_mem_q[rd_ptr_q];

  assign m0_readdata_o      = sdr_slave_readdata_i;
  assign m1_readdata_o      = sdr_slave_readdata_i;
  assign m0_readdatavalid_o = pop & ~head;
  assign m1_readdatavalid_o = pop & head;
  assign err_orphan_o       = err_orphan_q;

  // Slave port mux: granted master passes through, otherwise idle bus.
  always_comb begin
    sdr_slave_address_o      = '0;
    sdr_slave_byteenable_n_o = {BE_W{1'b1}};
    sdr_slave_chipselect_o   = 1'b0;
    sdr_slave_writedata_o    = '0;
    sdr_slave_read_n_o       = 1'b1;
    sdr_slave_write_n_o      = 1'b1;
    m0_waitrequest_o         = 1'b1;
    m1_waitrequest_o         = 1'b1;
    if (gnt) begin
      sdr_slave_address_o      = sel ? m1_address_i      : m0_address_i;
      sdr_slave_byteenable_n_o = sel ? m1_byteenable_n_i : m0_byteenable_n_i;
      sdr_slave_writedata_o    = sel ? m1_writedata_i    : m0_writedata_i;
      sdr_slave_chipselect_o   = (sel ? m1_chipselect_i : m0_chipselect_i) & ~block;
      sdr_slave_read_n_o       = (sel ? m1_read_n_i     : m0_read_n_i) | block;
      sdr_slave_write_n_o      = (sel ? m1_write_n_i    : m0_write_n_i) | block;
      if (sel) m1_waitrequest_o = sdr_slave_waitrequest_i | block;
      else     m0_waitrequest_o = sdr_slave_waitrequest_i | block;
    end
  end

  // Grant FSM: arbitrate in IDLE, leave a grant when the owner stops
  // requesting or its burst allowance is used up.
  always_comb begin
    state_d     = state_q;
    gnt_last_d  = gnt_last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = win ? GNT1 : GNT0;
          gnt_last_d  = win;
          burst_cnt_d = '0;
        end
      end
      GNT0, GNT1: begin
        if (accept) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (!s_req || (accept && burst_cnt_q == BURST_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ID FIFO bookkeeping and orphan detection.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q | (sdr_slave_readdatavalid_i & fifo_empty);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; gnt_last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      gnt_last_q   <= 1'b1;
      burst_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_last_q   <= gnt_last_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // ID storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wr_ptr_q] <= sel;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-master arbiter that shares the single Avalon-MM SDRAM controller slave port (`sdr_slave_*`) between the vector load/store unit (master 0) and a second requester such as a buffer/DMA engine (master 1). It grants the slave to one master at a time, holding the grant for bounded bursts of consecutive accepted transfers. It tracks outstanding reads in an ID FIFO so each `readdatavalid` returns to the master that issued the read. It sits between the requesters and the `sdram` controller instance in `top`.

## Interface
- `ADDR_W`, 25, address width of masters and slave
- `DATA_W`, 16, data width
- `BURST_MAX`, 16, max consecutive accepted transfers per grant (one 256-bit vector)
- `RD_DEPTH`, 8, outstanding-read ID FIFO depth, power of 2
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `mN_address`  in  ADDR_W  master N address (N = 0, 1)
- `mN_byteenable_n`  in  DATA_W/8  master N byte enables, active low
- `mN_chipselect`, `mN_read_n`, `mN_write_n`  in  1 each  master N command
- `mN_writedata`  in  DATA_W  master N write data
- `mN_readdata`  out  DATA_W  broadcast copy of `sdr_slave_readdata`
- `mN_readdatavalid`  out  1  routed read-valid
- `mN_waitrequest`  out  1  stall to master N
- `sdr_slave_address/byteenable_n/chipselect/writedata/read_n/write_n`  out  to controller
- `sdr_slave_readdata`  in  DATA_W, `sdr_slave_readdatavalid`  in  1, `sdr_slave_waitrequest`  in  1
- `err_orphan`  out  1  sticky: `readdatavalid` arrived with the ID FIFO empty

## Operation
- reqN = mN_chipselect & (~mN_read_n | ~mN_write_n). rdN = reqN & ~mN_read_n.
- States: IDLE, GNT0, GNT1 (registered). `gnt_last` records the last granted master. `burst_cnt` counts 0..BURST_MAX.
- IDLE: slave outputs are idle and both waitrequests are 1. If any req, the winner is registered into GNTx and `burst_cnt` is cleared.
- Round-robin winner: the sole requester; if both request, the master != gnt_last.
- GNTx: master x's command/address/data pass combinationally to the slave. `mx_waitrequest` = sdr_slave_waitrequest | block. The other master's waitrequest is 1.
- block = rdx & fifo_full. While block is set, the slave sees chipselect=0, read_n=1, write_n=1.
- Accepted transfer: GNTx & reqx & ~block & ~sdr_slave_waitrequest. Each accept increments `burst_cnt`. An accepted read pushes ID x into the FIFO.
- Leave GNTx for IDLE when reqx is deasserted, or when an accept brings `burst_cnt` to BURST_MAX. This gives a one-cycle bubble per re-arbitration.
- `sdr_slave_readdatavalid`: pop the FIFO head h, pulse `mh_readdatavalid` the same cycle (combinational). If the FIFO is empty, no master sees valid and `err_orphan` sets.
- A push and a pop in the same cycle are both performed. The full test uses the pre-pop count (a full FIFO blocks even with a concurrent pop).
- Reads and writes may interleave; write accepts do not touch the FIFO.

## Timing
- Arbitration latency: request in IDLE reaches the slave 1 cycle later.
- Burst throughput: 1 transfer/cycle while the controller has waitrequest=0.
- Read return: `readdatavalid` to the master is 0-cycle from the slave.
- Reset (async, any time, including mid-burst or with reads outstanding), then:
  - state=IDLE, gnt_last=1 (master 0 wins first tie), `burst_cnt`=0, FIFO empty, `err_orphan`=0.
  - slave chipselect=0, read_n=1, write_n=1, address/writedata=0, byteenable_n all 1.
  - both waitrequests 1, both readdatavalid 0, readdata follows the slave.
  - Reads in flight at reset are discarded; their later valids flag `err_orphan`.

## Configuration
- `SDR_ARB_FIXED_PRIO_EN` defined: in IDLE, master 0 always wins when it requests. `gnt_last` is unused. The BURST_MAX limit still forces return to IDLE.
- Not defined: round-robin as above.

## Test plan
- Single master 0 reads 16 words at 0x100..0x10F, slave waitrequest=0, latency 3: GNT0 for 16 accepts, then IDLE. 16 `m0_readdatavalid` pulses in order; m1 never sees valid.
- Both masters request continuously with BURST_MAX=4: grants alternate 0,1,0,1 in 4-accept bursts with a 1-cycle IDLE gap. With `SDR_ARB_FIXED_PRIO_EN` only master 0 is granted.
- RD_DEPTH=8 and slave read latency 20: master 1 issues 10 reads. After 8 accepts `m1_waitrequest` stays 1 and the slave chipselect stays 0 until the first valid pops; total accepts = 10, 10 valids routed to m1.
- Interleaved: m0 reads 2 and m1 reads 2 outstanding concurrently. Valids return as 0,0,1,1 to the matching masters; m0 write data 0xBEEF reaches the slave unchanged.
- Reset asserted mid-burst with 3 reads outstanding: outputs take their reset values immediately. The 3 late valids set `err_orphan`=1; a new m0 read afterwards completes normally.
- Slave waitrequest held 1 for 5 cycles during GNT0: m0 stalls 5 cycles, `burst_cnt` unchanged, no FIFO push until accept.
